regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_rport.sv | 51 +++++
 rtl/regfile_mp.sv | 79 +++++++
 tb/tb_regfile_mp.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;

   localparam int RF_WIDTH = 32;
   localparam int RF_DEPTH = 32;
   localparam int RF_NREAD = 2;

   // Address width for a given register count; never narrower than one bit.
   function automatic int addr_width(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/regfile_rport.sv
// One combinational read port: address decode, zero/out-of-range masking and,
// when REGFILE_BYPASS_EN is defined, forwarding of same-cycle accepted writes.
module regfile_rport
   import regfile_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH,
   parameter int DEPTH = RF_DEPTH,
   parameter int AW    = addr_width(RF_DEPTH)
) (
`ifdef REGFILE_BYPASS_EN
   input  logic                        acc_a_i,
   input  logic [AW-1:0]               wa_a_i,
   input  logic [WIDTH-1:0]            wd_a_i,
   input  logic                        acc_b_i,
   input  logic [AW-1:0]               wa_b_i,
   input  logic [WIDTH-1:0]            wd_b_i,
`endif
   input  logic [DEPTH-1:0][WIDTH-1:0] regs_i,
   input  logic [AW-1:0]               addr_i,
   output logic [WIDTH-1:0]            data_o
);

   logic [WIDTH-1:0] stored;

   // Addresses with no matching entry (>= DEPTH) fall through to zero.
   always_comb begin
      stored = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (addr_i == AW'(i)) begin
            stored = regs_i[i];
         end
      end
   end

`ifdef REGFILE_BYPASS_EN
   // acc_* already exclude address 0 and out-of-range targets; B wins a dual hit.
   always_comb begin
      data_o = stored;
      if (acc_b_i && (wa_b_i == addr_i)) begin
         data_o = wd_b_i;
      end else if (acc_a_i && (wa_a_i == addr_i)) begin
         data_o = wd_a_i;
      end else if (addr_i == '0) begin
         data_o = '0;
      end
   end
`else
   assign data_o = (addr_i == '0) ? '0 : stored;
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (B over A), NREAD combinational
// read ports, register 0 hardwired to zero. Optional macro: REGFILE_BYPASS_EN.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH,
   parameter int DEPTH = RF_DEPTH,
   parameter int NREAD = RF_NREAD,
   localparam int AW   = addr_width(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREAD*AW-1:0]    ra,
   output logic [NREAD*WIDTH-1:0] rd,
   input  logic                   we_a,
   input  logic                   we_b,
   input  logic [AW-1:0]          wa_a,
   input  logic [AW-1:0]          wa_b,
   input  logic [WIDTH-1:0]       wd_a,
   input  logic [WIDTH-1:0]       wd_b,
   output logic [DEPTH-1:0]       vld
);

   logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
   logic [DEPTH-1:0]            vld_q, vld_d;
   logic                        acc_a, acc_b;

   assign acc_a = we_a && (wa_a != '0) && (int'(wa_a) < DEPTH);
   assign acc_b = we_b && (wa_b != '0) && (int'(wa_b) < DEPTH);

   // B is applied after A so it overwrites A on an address collision.
   always_comb begin
      regs_d = regs_q;
      vld_d  = vld_q;
      if (acc_a) begin
         regs_d[wa_a] = wd_a;
         vld_d[wa_a]  = 1'b1;
      end
      if (acc_b) begin
         regs_d[wa_b] = wd_b;
         vld_d[wa_b]  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q <= '0;
         vld_q  <= '0;
      end else begin
         regs_q <= regs_d;
         vld_q  <= vld_d;
      end
   end

   assign vld = vld_q;

   generate
      for (genvar gi = 0; gi < NREAD; gi++) begin : g_rport
         regfile_rport #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .AW    (AW)
         ) u_rport (
`ifdef REGFILE_BYPASS_EN
            .acc_a_i (acc_a),
            .wa_a_i  (wa_a),
            .wd_a_i  (wd_a),
            .acc_b_i (acc_b),
            .wa_b_i  (wa_b),
            .wd_b_i  (wd_b),
`endif
            .regs_i  (regs_q),
            .addr_i  (ra[gi*AW +: AW]),
            .data_o  (rd[gi*WIDTH +: WIDTH])
         );
      end
   endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp at default parameters.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  ra;
   logic [63:0] rd;
   logic        we_a, we_b;
   logic [4:0]  wa_a, wa_b;
   logic [31:0] wd_a, wd_b;
   logic [31:0] vld;

   int vectors     = 0;
   int miscompares = 0;

   regfile_mp dut (
      .clk   (clk),
      .reset (reset),
      .ra    (ra),
      .rd    (rd),
      .we_a  (we_a),
      .we_b  (we_b),
      .wa_a  (wa_a),
      .wa_b  (wa_b),
      .wd_a  (wd_a),
      .wd_b  (wd_b),
      .vld   (vld)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] rd0();
      return rd[31:0];
   endfunction

   function automatic logic [31:0] rd1();
      return rd[63:32];
   endfunction

   function automatic logic [31:0] pat(input int i);
      return 32'(i) * 32'h0101_0101;
   endfunction

   initial begin
      reset = 1'b1;
      ra = '0; we_a = 1'b0; we_b = 1'b0;
      wa_a = '0; wa_b = '0; wd_a = '0; wd_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Reset state
      #1 check("reset_vld", vld, 32'h0);
      ra[4:0] = 5'd0;  #1 check("reset_rd_0", rd0(), 32'h0);
      ra[4:0] = 5'd5;  #1 check("reset_rd_5", rd0(), 32'h0);
      ra[4:0] = 5'd31; #1 check("reset_rd_31", rd0(), 32'h0);

      // Write/readback via port A
      we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEAD_BEEF;
      tick();
      we_a = 1'b0; ra[4:0] = 5'd5;
      #1 check("wr_rd5", rd0(), 32'hDEAD_BEEF);
      check("wr_vld5", 32'(vld[5]), 32'h1);

      // Writes to register 0 are dropped
      we_b = 1'b1; wa_b = 5'd0; wd_b = 32'h1234_5678;
      tick();
      we_b = 1'b0; ra[9:5] = 5'd0;
      #1 check("x0_rd", rd1(), 32'h0);
      check("x0_vld0", 32'(vld[0]), 32'h0);

      // Collision: B wins; both read ports see the same value
      we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h1111;
      we_b = 1'b1; wa_b = 5'd7; wd_b = 32'h2222;
      tick();
      we_a = 1'b0; we_b = 1'b0; ra[4:0] = 5'd7; ra[9:5] = 5'd7;
      #1 check("coll_rd0", rd0(), 32'h2222);
      check("coll_rd1", rd1(), 32'h2222);

      // Two distinct addresses in the same edge
      we_a = 1'b1; wa_a = 5'd10; wd_a = 32'hAAAA;
      we_b = 1'b1; wa_b = 5'd11; wd_b = 32'hBBBB;
      tick();
      we_a = 1'b0; we_b = 1'b0; ra[4:0] = 5'd10; ra[9:5] = 5'd11;
      #1 check("dual_rd10", rd0(), 32'hAAAA);
      check("dual_rd11", rd1(), 32'hBBBB);
      check("dual_vld", vld & 32'h0000_0CA0, 32'h0000_0CA0);

      // Same-cycle read of a register being written
      we_a = 1'b1; wa_a = 5'd3; wd_a = 32'h1234;
      tick();
      wd_a = 32'hCAFE; ra[4:0] = 5'd3;
      #1 check("byp_pre", rd0(), BYP ? 32'hCAFE : 32'h1234);
      tick();
      we_a = 1'b0;
      #1 check("byp_post", rd0(), 32'hCAFE);

      // Dual hit on the read address: B forwarded over A
      we_a = 1'b1; wa_a = 5'd4; wd_a = 32'h1;
      we_b = 1'b1; wa_b = 5'd4; wd_b = 32'h2;
      ra[9:5] = 5'd4;
      #1 check("byp_dual_pre", rd1(), BYP ? 32'h2 : 32'h0);
      tick();
      we_a = 1'b0; we_b = 1'b0;
      #1 check("byp_dual_post", rd1(), 32'h2);

      // Address 0 is never forwarded
      we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFF; ra[4:0] = 5'd0;
      #1 check("byp_x0", rd0(), 32'h0);
      tick();
      we_a = 1'b0;

      // Reset wins over a same-cycle write
      reset = 1'b1; we_a = 1'b1; wa_a = 5'd9; wd_a = 32'hFFFF;
      tick();
      reset = 1'b0; we_a = 1'b0; ra[4:0] = 5'd9; ra[9:5] = 5'd5;
      #1 check("rst_rd9", rd0(), 32'h0);
      check("rst_rd5", rd1(), 32'h0);
      check("rst_vld", vld, 32'h0);

      // Sweep: rd[0] shows the previous write, rd[1] the one in flight
      for (int i = 1; i < 32; i++) begin
         ra[4:0] = 5'(i - 1); ra[9:5] = 5'(i);
         we_a = 1'b1; wa_a = 5'(i); wd_a = pat(i);
         #1 check($sformatf("sweep_rd0_%0d", i), rd0(), pat(i - 1));
         check($sformatf("sweep_rd1_%0d", i), rd1(), BYP ? pat(i) : 32'h0);
         tick();
      end
      we_a = 1'b0;
      ra[4:0] = 5'd31;
      #1 check("sweep_last", rd0(), pat(31));
      check("sweep_vld", vld, 32'hFFFF_FFFE);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
